// File: rtl/axil_cmd_master_pkg.sv
// Shared constants and types for the AXI4-Lite command master.
package axil_cmd_master_pkg;

  // AXI response codes
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Unprivileged, secure, data access
  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    AXIL_M_IDLE    = 3'd0,
    AXIL_M_WR_REQ  = 3'd1,
    AXIL_M_WR_RESP = 3'd2,
    AXIL_M_RD_REQ  = 3'd3,
    AXIL_M_RD_RESP = 3'd4,
    AXIL_M_RSP     = 3'd5
  } axil_m_state_e;

endpackage

// File: rtl/axil_cmd_master_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count_next
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear, else increment unless already at all-ones
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The master latches the value the counter takes at the closing edge,
  // so the handshake cycle itself is included in the latency.
  assign count_next = count_d;

endmodule

// File: rtl/axil_cmd_master.sv
// AXI4-Lite single-outstanding master: one command in, one AXI transaction
// out, one response back with the measured transaction latency.
module axil_cmd_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LAT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic [LAT_WIDTH-1:0]    rsp_latency,
  output logic                    busy,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]              M_AXI_AWPROT,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  input  logic [1:0]              M_AXI_BRESP,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]              M_AXI_ARPROT,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY,
  input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP
);

  import axil_cmd_master_pkg::*;

  axil_m_state_e state_q, state_d;

  logic                    cmd_ready_q, cmd_ready_d;
  logic                    busy_q, busy_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    bready_q, bready_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]              rsp_resp_q, rsp_resp_d;
  logic [LAT_WIDTH-1:0]    rsp_latency_q, rsp_latency_d;

  logic                    cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs;
  logic                    lat_en;
  logic [LAT_WIDTH-1:0]    lat_next;

  assign cmd_hs = cmd_valid & cmd_ready_q;
  assign aw_hs  = awvalid_q & M_AXI_AWREADY;
  assign w_hs   = wvalid_q & M_AXI_WREADY;
  assign b_hs   = bready_q & M_AXI_BVALID;
  assign ar_hs  = arvalid_q & M_AXI_ARREADY;
  assign r_hs   = rready_q & M_AXI_RVALID;
  assign rsp_hs = rsp_valid_q & rsp_ready;

  assign lat_en = (state_q == AXIL_M_WR_REQ) || (state_q == AXIL_M_WR_RESP) ||
                  (state_q == AXIL_M_RD_REQ) || (state_q == AXIL_M_RD_RESP);

  sat_counter #(
    .WIDTH (LAT_WIDTH)
  ) u_lat (
    .clk        (clk),
    .rst        (rst),
    .clr        (cmd_hs),
    .en         (lat_en),
    .count_next (lat_next)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= AXIL_M_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      AXIL_M_IDLE: begin
        if (cmd_hs) begin
          state_d = cmd_write ? AXIL_M_WR_REQ : AXIL_M_RD_REQ;
        end
      end
      AXIL_M_WR_REQ: begin
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d = AXIL_M_WR_RESP;
        end
      end
      AXIL_M_WR_RESP: if (b_hs)   state_d = AXIL_M_RSP;
      AXIL_M_RD_REQ:  if (ar_hs)  state_d = AXIL_M_RD_RESP;
      AXIL_M_RD_RESP: if (r_hs)   state_d = AXIL_M_RSP;
      AXIL_M_RSP:     if (rsp_hs) state_d = AXIL_M_IDLE;
      default:        state_d = AXIL_M_IDLE;
    endcase
  end

  // Next values of every registered output, decoded from the next state
  // so each handshake signal is a flop rather than a gate on the state.
  always_comb begin
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    rsp_write_d   = rsp_write_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_latency_d = rsp_latency_q;

    if (cmd_hs) begin
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
      addr_d    = cmd_addr;
      wdata_d   = cmd_wdata;
      wstrb_d   = cmd_wstrb;
    end
    if (aw_hs) aw_done_d = 1'b1;
    if (w_hs)  w_done_d  = 1'b1;

    // AW and W retire independently; each VALID falls after its own handshake
    awvalid_d   = (state_d == AXIL_M_WR_REQ) && !aw_done_d;
    wvalid_d    = (state_d == AXIL_M_WR_REQ) && !w_done_d;
    bready_d    = (state_d == AXIL_M_WR_RESP);
    arvalid_d   = (state_d == AXIL_M_RD_REQ);
    rready_d    = (state_d == AXIL_M_RD_RESP);
    rsp_valid_d = (state_d == AXIL_M_RSP);
    cmd_ready_d = (state_d == AXIL_M_IDLE);
    busy_d      = (state_d != AXIL_M_IDLE);

    if (b_hs) begin
      rsp_write_d   = 1'b1;
      rsp_rdata_d   = '0;
      rsp_resp_d    = M_AXI_BRESP;
      rsp_latency_d = lat_next;
    end
    if (r_hs) begin
      rsp_write_d   = 1'b0;
      rsp_rdata_d   = M_AXI_RDATA;
      rsp_resp_d    = M_AXI_RRESP;
      rsp_latency_d = lat_next;
    end
  end

  // Output and payload registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_write_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      rsp_latency_q <= '0;
    end else begin
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_write_q   <= rsp_write_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_latency_q <= rsp_latency_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign busy          = busy_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_write     = rsp_write_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_latency   = rsp_latency_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = AXI_PROT_DEFAULT;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = AXI_PROT_DEFAULT;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master with a configurable-latency AXI4-Lite slave.
module tb_axil_cmd_master;

  import axil_cmd_master_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_write, busy;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [LW-1:0] rsp_latency;
  logic          awvalid, awready = 1'b0, wvalid, wready = 1'b0;
  logic          bvalid = 1'b0, bready, arvalid, arready = 1'b0;
  logic          rvalid = 1'b0, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [DW-1:0] wdata, rdata = '0;
  logic [3:0]    wstrb;
  logic [2:0]    awprot, arprot;
  logic [1:0]    bresp = '0, rresp = '0;

  always #5 clk = ~clk;

  axil_cmd_master #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .LAT_WIDTH  (LW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .cmd_wstrb     (cmd_wstrb),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_write     (rsp_write),
    .rsp_rdata     (rsp_rdata),
    .rsp_resp      (rsp_resp),
    .rsp_latency   (rsp_latency),
    .busy          (busy),
    .M_AXI_AWVALID (awvalid),
    .M_AXI_AWREADY (awready),
    .M_AXI_AWADDR  (awaddr),
    .M_AXI_AWPROT  (awprot),
    .M_AXI_WVALID  (wvalid),
    .M_AXI_WREADY  (wready),
    .M_AXI_WDATA   (wdata),
    .M_AXI_WSTRB   (wstrb),
    .M_AXI_BVALID  (bvalid),
    .M_AXI_BREADY  (bready),
    .M_AXI_BRESP   (bresp),
    .M_AXI_ARVALID (arvalid),
    .M_AXI_ARREADY (arready),
    .M_AXI_ARADDR  (araddr),
    .M_AXI_ARPROT  (arprot),
    .M_AXI_RVALID  (rvalid),
    .M_AXI_RREADY  (rready),
    .M_AXI_RDATA   (rdata),
    .M_AXI_RRESP   (rresp)
  );

  // Slave configuration: *_wait = VALID cycles before READY (-1 = READY tied high),
  // *_lat = cycles from address/data handshake to response VALID.
  int          aw_wait = -1, w_wait = -1, ar_wait = -1, b_lat = 1, r_lat = 1;
  logic [1:0]  b_resp_cfg = AXI_RESP_OKAY, r_resp_cfg = AXI_RESP_OKAY;
  logic [31:0] r_data_cfg = '0;

  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
  bit aw_got = 0, w_got = 0, ar_got = 0, b_fire = 0, r_fire = 0;

  // Slave model: updates on the falling edge, so every decision it makes is
  // seen by the DUT at the next rising edge.
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
      aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
    end else begin
      if (b_fire) begin bvalid = 0; b_fire = 0; end
      if (r_fire) begin rvalid = 0; r_fire = 0; end
      if (aw_got && w_got) begin
        b_cnt++;
        if (b_cnt >= b_lat) begin
          bvalid = 1; bresp = b_resp_cfg; aw_got = 0; w_got = 0; b_cnt = 0;
        end
      end
      if (ar_got) begin
        r_cnt++;
        if (r_cnt >= r_lat) begin
          rvalid = 1; rdata = r_data_cfg; rresp = r_resp_cfg; ar_got = 0; r_cnt = 0;
        end
      end
      if (aw_wait < 0) awready = 1;
      else if (awvalid) begin awready = (aw_cnt == aw_wait); aw_cnt++; end
      else begin awready = 0; aw_cnt = 0; end
      if (w_wait < 0) wready = 1;
      else if (wvalid) begin wready = (w_cnt == w_wait); w_cnt++; end
      else begin wready = 0; w_cnt = 0; end
      if (ar_wait < 0) arready = 1;
      else if (arvalid) begin arready = (ar_cnt == ar_wait); ar_cnt++; end
      else begin arready = 0; ar_cnt = 0; end
      if (awvalid && awready) aw_got = 1;
      if (wvalid && wready) w_got = 1;
      if (arvalid && arready) ar_got = 1;
      if (bvalid && bready) b_fire = 1;
      if (rvalid && rready) r_fire = 1;
    end
  end

  // Protocol monitor: running totals, compared as deltas around each test
  int awv_n = 0, wv_n = 0, arv_n = 0, arv_rise = 0;
  int aw_unstable = 0, w_unstable = 0, ar_unstable = 0, bready_early = 0;
  logic          p_awv = 0, p_wv = 0, p_arv = 0;
  logic [AW-1:0] p_awaddr = '0, p_araddr = '0;
  logic [DW-1:0] p_wdata = '0;

  always @(negedge clk) begin
    if (rst) begin
      if (awvalid) awv_n++;
      if (wvalid) wv_n++;
      if (arvalid) arv_n++;
      if (arvalid && !p_arv) arv_rise++;
      if (awvalid && p_awv && (awaddr != p_awaddr)) aw_unstable++;
      if (wvalid && p_wv && (wdata != p_wdata)) w_unstable++;
      if (arvalid && p_arv && (araddr != p_araddr)) ar_unstable++;
      if (bready && (awvalid || wvalid)) bready_early++;
    end
    p_awv = awvalid; p_wv = wvalid; p_arv = arvalid;
    p_awaddr = awaddr; p_wdata = wdata; p_araddr = araddr;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Present a command at a falling edge; returns in the first cycle after acceptance
  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    int n = 0;
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("cmd_accept", {63'd0, cmd_ready}, 64'd1);
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("rsp_valid", {63'd0, rsp_valid}, 64'd1);
  endtask

  task automatic ack_rsp();
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    check("rsp_done", {62'd0, rsp_valid, cmd_ready}, 64'b01);
  endtask

  int s_awv, s_wv, s_arv, s_rise, s_awu, s_wu, s_aru, s_be;

  task automatic snap();
    s_awv = awv_n; s_wv = wv_n; s_arv = arv_n; s_rise = arv_rise;
    s_awu = aw_unstable; s_wu = w_unstable; s_aru = ar_unstable; s_be = bready_early;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_ctl", {57'd0, awvalid, wvalid, bready, arvalid, rready, rsp_valid, busy}, 64'd0);
    check("reset_rsp", {rsp_write, rsp_resp, rsp_latency, rsp_rdata}, 64'd0);
    check("reset_payload", {awaddr, wdata}, 64'd0);
    rst = 1;
    @(negedge clk);
    check("post_reset", {62'd0, cmd_ready, busy}, 64'b10);
    check("prot", {58'd0, awprot, arprot}, 64'd0);

    // 1: zero-wait write
    aw_wait = -1; w_wait = -1; b_lat = 1; b_resp_cfg = AXI_RESP_OKAY;
    snap();
    send_cmd(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    check("t1_valids", {62'd0, awvalid, wvalid}, 64'b11);
    check("t1_awaddr", awaddr, 64'h10);
    check("t1_wdata", wdata, 64'hDEAD_BEEF);
    check("t1_wstrb", wstrb, 64'hF);
    wait_rsp();
    check("t1_awv_cycles", awv_n - s_awv, 1);
    check("t1_wv_cycles", wv_n - s_wv, 1);
    check("t1_rsp", {rsp_write, rsp_resp, rsp_rdata}, {31'd0, 1'b1, AXI_RESP_OKAY, 32'd0});
    check("t1_latency", rsp_latency, 2);
    ack_rsp();

    // 2: read, ARREADY after 3 extra cycles, RVALID 2 cycles after AR handshake
    ar_wait = 3; r_lat = 2; r_data_cfg = 32'h1234_5678; r_resp_cfg = AXI_RESP_OKAY;
    snap();
    send_cmd(1'b0, 32'h0000_0040, 32'h0, 4'h0);
    check("t2_arvalid", {arvalid, araddr}, {31'd0, 1'b1, 32'h40});
    wait_rsp();
    check("t2_arv_cycles", arv_n - s_arv, 4);
    check("t2_rsp", {rsp_write, rsp_resp, rsp_rdata}, {31'd0, 1'b0, AXI_RESP_OKAY, 32'h1234_5678});
    check("t2_latency", rsp_latency, 6);
    ack_rsp();

    // 3: W accepted in first cycle, AW on the fourth
    w_wait = 0; aw_wait = 3; b_lat = 1;
    snap();
    send_cmd(1'b1, 32'h0000_0080, 32'h0102_0304, 4'h3);
    wait_rsp();
    check("t3_wv_cycles", wv_n - s_wv, 1);
    check("t3_awv_cycles", awv_n - s_awv, 4);
    check("t3_aw_stable", aw_unstable - s_awu, 0);
    check("t3_bready_order", bready_early - s_be, 0);
    check("t3_rsp", {rsp_write, rsp_resp}, {61'd0, 1'b1, AXI_RESP_OKAY});
    check("t3_latency", rsp_latency, 5);
    ack_rsp();

    // 4: SLVERR with response backpressure and a queued second command
    aw_wait = -1; w_wait = -1; b_lat = 1; b_resp_cfg = AXI_RESP_SLVERR;
    send_cmd(1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 4'hF);
    wait_rsp();
    ar_wait = 0; r_lat = 1; r_data_cfg = 32'hCAFE_F00D; r_resp_cfg = AXI_RESP_DECERR;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h0000_0044;
    for (int i = 0; i < 5; i++) begin
      check("t4_hold", {rsp_valid, rsp_resp, cmd_ready, rsp_write, rsp_latency},
            {55'd0, 1'b1, AXI_RESP_SLVERR, 1'b0, 1'b1, 4'd2});
      @(negedge clk);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    check("t4_idle_after_rsp", {61'd0, rsp_valid, cmd_ready, busy}, 64'b010);
    @(negedge clk);
    cmd_valid = 0;
    check("t4_second_accepted", {busy, arvalid, araddr}, {30'd0, 2'b11, 32'h44});
    wait_rsp();
    check("t4_second_rsp", {rsp_write, rsp_resp, rsp_rdata}, {31'd0, 1'b0, AXI_RESP_DECERR, 32'hCAFE_F00D});
    check("t4_second_latency", rsp_latency, 2);
    ack_rsp();

    // 5: latency saturation, ARREADY withheld for 20 cycles
    ar_wait = 20; r_lat = 1; r_data_cfg = 32'h0BAD_F00D; r_resp_cfg = AXI_RESP_EXOKAY;
    snap();
    send_cmd(1'b0, 32'h0000_0100, 32'h0, 4'h0);
    wait_rsp();
    check("t5_arv_cycles", arv_n - s_arv, 21);
    check("t5_arv_continuous", arv_rise - s_rise, 1);
    check("t5_ar_stable", ar_unstable - s_aru, 0);
    check("t5_rsp", {rsp_resp, rsp_rdata}, {30'd0, AXI_RESP_EXOKAY, 32'h0BAD_F00D});
    check("t5_latency", rsp_latency, 15);
    ack_rsp();
    check("t1t5_w_stable", w_unstable, 0);

    // 6: asynchronous reset while AWVALID is high
    aw_wait = 50; w_wait = -1;
    send_cmd(1'b1, 32'h0000_0200, 32'h5555_AAAA, 4'hF);
    check("t6_awvalid_pre", {63'd0, awvalid}, 64'd1);
    #3;
    rst = 0;
    #1;
    check("t6_async_reset", {58'd0, awvalid, wvalid, bready, arvalid, rready, busy}, 64'd0);
    @(negedge clk);
    aw_wait = -1;
    rst = 1;
    @(negedge clk);
    check("t6_after_release", {61'd0, cmd_ready, busy, rsp_valid}, 64'b100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axil_cmd_master.md
Name: axil_cmd_master

Overview:
- AXI4-Lite master (initiator) that turns single-beat command requests into AXI4-Lite write or read transactions, and returns the response to the requester.
- Drives the soc_control slave port from the PS-side test harness and from the fault injection module. Used for register dump, single-register read and single-register write (with or without fault).
- Handles one outstanding transaction at a time. Also measures per-transaction latency for profiling.

Parameters:
- ADDR_WIDTH, default 32 (`C_AXI_ADDR_WIDTH): AXI address width.
- DATA_WIDTH, default 32 (`C_AXI_DATA_WIDTH): AXI data width. STRB width is DATA_WIDTH/8.
- LAT_WIDTH, default 16: width of the latency counter. The counter saturates at its maximum.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  DATA_WIDTH/8  write strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  echoes the command type.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP as captured.
- rsp_latency  out  LAT_WIDTH  cycles from first VALID to response handshake.
- busy  out  1  high in any state other than IDLE.
- M_AXI_AWVALID out 1; M_AXI_AWREADY in 1; M_AXI_AWADDR out ADDR_WIDTH; M_AXI_AWPROT out 3.
- M_AXI_WVALID out 1; M_AXI_WREADY in 1; M_AXI_WDATA out DATA_WIDTH; M_AXI_WSTRB out DATA_WIDTH/8.
- M_AXI_BVALID in 1; M_AXI_BREADY out 1; M_AXI_BRESP in 2.
- M_AXI_ARVALID out 1; M_AXI_ARREADY in 1; M_AXI_ARADDR out ADDR_WIDTH; M_AXI_ARPROT out 3.
- M_AXI_RVALID in 1; M_AXI_RREADY out 1; M_AXI_RDATA in DATA_WIDTH; M_AXI_RRESP in 2.

Behaviour:
- Clock and reset (already decided): one clock, clk. Reset rst is asynchronous and active-low.
- Reset values:
  - all VALID and READY outputs = 0, except cmd_ready = 1 once out of reset.
  - rsp_* = 0, busy = 0, AW/AR/W address and data registers = 0, state = IDLE.
- AWPROT and ARPROT are constant 3'b000. All outputs are registered; there are no combinational paths from inputs to outputs.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE:
  - cmd_ready = 1.
  - On command handshake, capture addr/wdata/wstrb/write and clear the latency counter.
  - Next state is WR_REQ if cmd_write, else RD_REQ.
- WR_REQ:
  - AWVALID and WVALID both rise in the first WR_REQ cycle (one cycle after command handshake).
  - Each VALID drops independently in the cycle after its own handshake. The AW and W handshakes may occur in either order or in the same cycle.
  - Go to WR_RESP once both handshakes have completed.
  - The AW/W payload is stable while its VALID is high.
- WR_RESP:
  - BREADY = 1.
  - On the BVALID handshake, capture BRESP, set rsp_write = 1 and rsp_rdata = 0, then go to RSP.
- RD_REQ:
  - ARVALID = 1 until the ARREADY handshake, then go to RD_RESP.
- RD_RESP:
  - RREADY = 1.
  - On the RVALID handshake, capture RDATA and RRESP, set rsp_write = 0, then go to RSP.
- RSP:
  - rsp_valid = 1, and the rsp_* values are held stable until rsp_ready.
  - Return to IDLE on the response handshake. The next command can be accepted in the following cycle.
- The master never drops a VALID before its handshake and never waits on READY before asserting VALID.
- A slave READY asserted before VALID is legal and must complete the handshake in the VALID-rise cycle.
- Latency counter:
  - Increments every cycle from the first REQ-state cycle up to and including the BVALID/RVALID handshake cycle.
  - Saturates at 2^LAT_WIDTH-1 and never wraps.
  - Latched into rsp_latency on entry to RSP.
- SLVERR/DECERR responses are passed through unchanged. The master takes no retry action.
- cmd_valid while busy is ignored (cmd_ready = 0). The requester must hold the command stable until it is accepted.
- Reset asserted mid-transaction: immediate return to reset values. The slave must share the same reset.

Decomposition:
- The shared include rv32i_params.vh gains the following constants:
  - AXI response codes: AXI_RESP_OKAY = 2'b00, AXI_RESP_EXOKAY = 2'b01, AXI_RESP_SLVERR = 2'b10, AXI_RESP_DECERR = 2'b11.
  - State encodings: AXIL_M_IDLE … AXIL_M_RSP, 3 bits.
- The saturating latency counter is a natural sub-module: sat_counter, with parameter WIDTH and inputs clr/en.

Test Plan:
- Write, zero-wait slave, AW/W/B READY tied high: cmd addr 0x0000_0010, data 0xDEAD_BEEF, strb 0xF.
  - Required: AWVALID and WVALID high for exactly 1 cycle; AWADDR 0x10; WDATA 0xDEADBEEF.
  - Then rsp_valid with rsp_resp 00 and rsp_latency 2.
- Read, RREADY, ARREADY delayed 3 cycles; RVALID 2 cycles after AR handshake with RDATA 0x1234_5678, RRESP 00.
  - Required: rsp_rdata 0x12345678, rsp_write 0, rsp_latency 6.
- Write ordering: WREADY in cycle 1, AWREADY in cycle 4.
  - Required: WVALID drops after cycle 1; AWVALID stays high with AWADDR stable until cycle 4; BREADY rises only after both handshakes.
- Error and backpressure: slave returns BRESP 10 and rsp_ready is held low for 5 cycles.
  - Required: rsp_valid and rsp_resp = 10 held stable; cmd_ready stays 0; a second cmd_valid is not accepted until the cycle after rsp_ready.
- Saturation: LAT_WIDTH = 4, ARREADY withheld for 20 cycles.
  - Required: ARVALID held continuously; rsp_latency = 15.
- Reset mid-transaction: rst asserted while AWVALID = 1.
  - Required: all M_AXI VALID/READY outputs drop to 0 asynchronously; after release, cmd_ready = 1 and busy = 0.
